// File: rtl/write_through_cache_system.sv
// Direct-mapped, write-through, no-write-allocate data cache with its main memory.
// 32 lines of 4 words; word address = {tag, index[4:0], offset[1:0]}.

// Main memory: synchronous RAM with a one-cycle read latency.
module mainMemory #(
  parameter int AW = 10,
  parameter int W  = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wrData,
  output logic [W-1:0]  rdData
);
  logic [W-1:0] RAM [0:(2**AW)-1];

  // Write the addressed word and register the read data.
  always_ff @(posedge clk) begin
    if (we) RAM[addr] <= wrData;
    rdData <= RAM[addr];
  end
endmodule

// Cache storage: line data, tags and valid bits with a combinational lookup port.
module directMappedCache #(
  parameter int IDX_W = 5,
  parameter int TAG_W = 3,
  parameter int W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] lookupIdx,
  output logic [4*W-1:0]   lineOut,
  output logic [TAG_W-1:0] tagOut,
  output logic             validOut,
  input  logic             wordWe,
  input  logic [IDX_W-1:0] wrIdx,
  input  logic [1:0]       wrOff,
  input  logic [W-1:0]     wrData,
  input  logic             invEn,
  input  logic             fillDone,
  input  logic [TAG_W-1:0] fillTag
);
  localparam int LINES = 2**IDX_W;

  logic [4*W-1:0]   CACHE [0:LINES-1];
  logic [TAG_W-1:0] tags  [0:LINES-1];
  logic [LINES-1:0] valid;

  assign lineOut  = CACHE[lookupIdx];
  assign tagOut   = tags[lookupIdx];
  assign validOut = valid[lookupIdx];

  // Data and tag storage; not cleared by reset.
  always_ff @(posedge clk) begin
    for (int w = 0; w < 4; w++) begin
      if (wordWe && wrOff == w[1:0]) CACHE[wrIdx][w*W +: W] <= wrData;
    end
    if (fillDone) tags[wrIdx] <= fillTag;
  end

  // Valid bits: cleared on reset, dropped when a refill starts, set when it completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
    end else if (fillDone) begin
      valid[wrIdx] <= 1'b1;
    end else if (invEn) begin
      valid[wrIdx] <= 1'b0;
    end
  end
endmodule

// Top: request FSM steering the cache and main memory.
module write_through_cache_system #(
  parameter int address_width = 10,
  parameter int WIDTH         = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [address_width-1:0] WordAddress,
  input  logic [WIDTH-1:0]         DataIn,
  input  logic                     mem_read,
  input  logic                     mem_write,
  output logic                     stall,
  output logic [WIDTH-1:0]         DataOut
);
  localparam int IDX_W = 5;
  localparam int TAG_W = address_width - IDX_W - 2;

  typedef enum logic [1:0] {IDLE, WRITE, REFILL} stateT;

  stateT                    state, nextState;
  logic [address_width-1:0] addrLat;
  logic [WIDTH-1:0]         dataLat;
  logic [2:0]               fillCnt;
  logic [WIDTH-1:0]         dataOutReg;

  logic [IDX_W-1:0] reqIdx;
  logic [TAG_W-1:0] reqTag;
  logic [1:0]       reqOff;
  logic [4*WIDTH-1:0] lineOut;
  logic [TAG_W-1:0] tagOut;
  logic             validOut;
  logic             hit;
  logic [WIDTH-1:0] hitWord;

  logic                     memWe;
  logic [address_width-1:0] memAddr;
  logic [WIDTH-1:0]         memRdata;
  logic                     wordWe;
  logic [IDX_W-1:0]         wrIdx;
  logic [1:0]               wrOff;
  logic [WIDTH-1:0]         wrData;
  logic                     invEn;
  logic                     fillDone;
  logic                     loadOut;
  logic                     latchReq;

  assign reqOff = WordAddress[1:0];
  assign reqIdx = WordAddress[IDX_W+1:2];
  assign reqTag = WordAddress[address_width-1:IDX_W+2];
  assign hit    = validOut && (tagOut == reqTag);

  mainMemory #(.AW(address_width), .W(WIDTH)) Main_Memory_U0 (
    .clk    (clk),
    .we     (memWe),
    .addr   (memAddr),
    .wrData (dataLat),
    .rdData (memRdata)
  );

  directMappedCache #(.IDX_W(IDX_W), .TAG_W(TAG_W), .W(WIDTH)) Cache (
    .clk       (clk),
    .reset     (reset),
    .lookupIdx (reqIdx),
    .lineOut   (lineOut),
    .tagOut    (tagOut),
    .validOut  (validOut),
    .wordWe    (wordWe),
    .wrIdx     (wrIdx),
    .wrOff     (wrOff),
    .wrData    (wrData),
    .invEn     (invEn),
    .fillDone  (fillDone),
    .fillTag   (addrLat[address_width-1:IDX_W+2])
  );

  // Select the requested word out of the looked-up line.
  always_comb begin
    hitWord = '0;
    for (int w = 0; w < 4; w++) begin
      if (reqOff == w[1:0]) hitWord = lineOut[w*WIDTH +: WIDTH];
    end
  end

  // Next-state logic and datapath steering for every state.
  always_comb begin
    nextState = state;
    stall     = 1'b0;
    DataOut   = dataOutReg;
    memWe     = 1'b0;
    memAddr   = {addrLat[address_width-1:2], fillCnt[1:0]};
    wordWe    = 1'b0;
    wrIdx     = reqIdx;
    wrOff     = reqOff;
    wrData    = DataIn;
    invEn     = 1'b0;
    fillDone  = 1'b0;
    loadOut   = 1'b0;
    latchReq  = 1'b0;
    case (state)
      IDLE: begin
        if (mem_write) begin
          stall     = 1'b1;
          wordWe    = hit;
          latchReq  = 1'b1;
          nextState = WRITE;
        end else if (mem_read) begin
          if (hit) begin
            DataOut = hitWord;
            loadOut = 1'b1;
          end else begin
            stall     = 1'b1;
            invEn     = 1'b1;
            latchReq  = 1'b1;
            nextState = REFILL;
          end
        end
      end
      WRITE: begin
        stall     = 1'b1;
        memWe     = 1'b1;
        memAddr   = addrLat;
        nextState = IDLE;
      end
      REFILL: begin
        // Memory data lags its address by one cycle, so word k lands while fillCnt is k+1.
        stall  = 1'b1;
        wrIdx  = addrLat[IDX_W+1:2];
        wrOff  = fillCnt[1:0] - 2'd1;
        wrData = memRdata;
        wordWe = (fillCnt != 3'd0);
        if (fillCnt == 3'd4) begin
          fillDone  = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Control registers: state, refill counter and the held read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      fillCnt    <= '0;
      dataOutReg <= '0;
    end else begin
      state <= nextState;
      if (state == REFILL) fillCnt <= fillCnt + 3'd1;
      else                 fillCnt <= '0;
      if (loadOut) dataOutReg <= hitWord;
    end
  end

  // Request capture for the write and refill states.
  always_ff @(posedge clk) begin
    if (latchReq) begin
      addrLat <= WordAddress;
      dataLat <= DataIn;
    end
  end
endmodule

// File: tb/tb_write_through_cache_system.sv
// Directed bench for write_through_cache_system with hand-computed expectations.
module tb_write_through_cache_system;
  logic        clk;
  logic        reset;
  logic [9:0]  WordAddress;
  logic [31:0] DataIn;
  logic        mem_read;
  logic        mem_write;
  logic        stall;
  logic [31:0] DataOut;

  int checks   = 0;
  int failures = 0;

  write_through_cache_system #(.address_width(10), .WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .WordAddress (WordAddress),
    .DataIn      (DataIn),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .stall       (stall),
    .DataOut     (DataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Write request held for one cycle; waits (bounded) for stall to drop.
  task automatic writeWord(input string tag, input logic [9:0] a, input logic [31:0] d,
                           input logic alsoRead);
    int waited;
    @(posedge clk); #1;
    WordAddress = a; DataIn = d; mem_write = 1'b1; mem_read = alsoRead;
    @(negedge clk);
    checkEq({tag, "_stallOn"}, {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    mem_write = 1'b0; mem_read = 1'b0;
    waited = 1;
    while (stall && waited < 4) begin
      @(posedge clk); #1;
      waited++;
    end
    checkEq({tag, "_within2"}, {31'd0, (stall == 1'b0 && waited <= 2)}, 32'd1);
  endtask

  // Read request held until stall drops (bounded); returns data and stalled cycles.
  task automatic readWord(input logic [9:0] a, output logic [31:0] d, output int waited);
    @(posedge clk); #1;
    WordAddress = a; mem_read = 1'b1;
    waited = 0;
    @(negedge clk);
    while (stall && waited < 10) begin
      @(posedge clk); @(negedge clk);
      waited++;
    end
    d = DataOut;
    @(posedge clk); #1;
    mem_read = 1'b0;
  endtask

  logic [31:0] rd;
  int          wt;
  logic [9:0]  hitAddrs [4]   = '{10'h000, 10'h001, 10'h002, 10'h003};
  logic [31:0] lineZero [4]   = '{32'h5, 32'h15, 32'h25, 32'h35};
  logic [9:0]  evictAddrs [4] = '{10'h020, 10'h040, 10'h060, 10'h00A};
  logic [31:0] hitData [4]    = '{32'h11, 32'h22, 32'h33, 32'h44};

  initial begin
    reset = 1'b1; WordAddress = '0; DataIn = '0; mem_read = 1'b0; mem_write = 1'b0;
    for (int i = 0; i < 1024; i++) dut.Main_Memory_U0.RAM[i] = 32'(i);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkEq("rst_stall", {31'd0, stall}, 32'd0);
    checkEq("rst_dout", DataOut, 32'd0);
    checkEq("rst_valid", dut.Cache.valid, 32'd0);

    // Write misses: memory only, no allocation.
    for (int i = 0; i < 4; i++) begin
      writeWord($sformatf("wmiss%0d", i), hitAddrs[i], lineZero[i], 1'b0);
      checkEq($sformatf("wmiss%0d_ram", i), dut.Main_Memory_U0.RAM[hitAddrs[i]], lineZero[i]);
    end
    checkEq("wmiss_line0_invalid", {31'd0, dut.Cache.valid[0]}, 32'd0);

    // Highest address: write then read-miss refill.
    writeWord("w3ff", 10'h3FF, 32'h5C79, 1'b0);
    readWord(10'h3FF, rd, wt);
    checkEq("r3ff_data", rd, 32'h5C79);
    checkEq("r3ff_latency", {31'd0, (wt >= 1 && wt <= 6)}, 32'd1);
    checkEq("r3ff_valid", {31'd0, dut.Cache.valid[31]}, 32'd1);

    // Read miss on line 0, then hits on every word of it.
    readWord(10'h001, rd, wt);
    checkEq("r001_data", rd, 32'h15);
    checkEq("r001_miss", {31'd0, (wt >= 1 && wt <= 6)}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      readWord(hitAddrs[i], rd, wt);
      checkEq($sformatf("hit%0d_data", i), rd, lineZero[i]);
      checkEq($sformatf("hit%0d_nostall", i), 32'(wt), 32'd0);
    end

    // Reads on lines 8, 16, 24 and 2 from the preloaded memory.
    for (int i = 0; i < 4; i++) begin
      readWord(evictAddrs[i], rd, wt);
      checkEq($sformatf("evict%0d_data", i), rd, 32'(evictAddrs[i]));
    end

    // Write hits on line 2 update both cache and memory.
    for (int i = 0; i < 4; i++) begin
      writeWord($sformatf("whit%0d", i), 10'(8 + i), hitData[i], 1'b0);
      checkEq($sformatf("whit%0d_ram", i), dut.Main_Memory_U0.RAM[8 + i], hitData[i]);
    end
    checkEq("whit_cache_w0", dut.Cache.CACHE[2][31:0],   32'h11);
    checkEq("whit_cache_w3", dut.Cache.CACHE[2][127:96], 32'h44);
    readWord(10'h009, rd, wt);
    checkEq("whit_readback", rd, 32'h22);
    checkEq("whit_readback_hit", 32'(wt), 32'd0);

    writeWord("w060", 10'h060, 32'h0, 1'b0);
    checkEq("w060_ram", dut.Main_Memory_U0.RAM[10'h060], 32'h0);
    checkEq("w060_cache", dut.Cache.CACHE[24][31:0], 32'h0);

    // Write wins when both requests are high; line 1 stays unallocated.
    writeWord("wboth", 10'h004, 32'h77, 1'b1);
    checkEq("wboth_ram", dut.Main_Memory_U0.RAM[4], 32'h77);
    checkEq("wboth_noalloc", {31'd0, dut.Cache.valid[1]}, 32'd0);

    // Reset in the middle of a refill of line 0.
    @(posedge clk); #1;
    WordAddress = 10'h100; mem_read = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1; mem_read = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checkEq("abort_valid0", {31'd0, dut.Cache.valid[0]}, 32'd0);
    checkEq("abort_stall", {31'd0, stall}, 32'd0);
    checkEq("abort_dout", DataOut, 32'd0);
    readWord(10'h002, rd, wt);
    checkEq("post_reset_data", rd, 32'h25);
    checkEq("post_reset_miss", {31'd0, (wt >= 1 && wt <= 6)}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
